// File: rtl/mem_dma_pkg.sv
// Shared definitions for the mem_dma block-copy initiator: FSM encoding, default
// byte step per word and word-alignment helper.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DMA_STEP = 2;

    // The memory indexes words by a[15:1], so byte addresses are always presented even.
    function automatic logic [15:0] word_align(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_dma_addr_ctr.sv
// dma_addr_ctr: loadable 16-bit byte-address pointer that advances by STEP per word
// and always presents a word-aligned (bit0 clear) address.
module dma_addr_ctr
    import mem_dma_pkg::*;
#(
    parameter int unsigned STEP = DMA_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [15:0] load_val,
    output logic [15:0] ptr
);

    logic [15:0] ptr_q;

    // Increment wraps modulo 2**16, so 0xFFFE steps to 0x0000.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (load) begin
            ptr_q <= word_align(load_val);
        end else if (inc) begin
            ptr_q <= ptr_q + 16'(STEP);
        end
    end

    assign ptr = word_align(ptr_q);

endmodule

// File: rtl/mem_dma.sv
// mem_dma: copies len 16-bit words from src to dst over a single-port word memory.
// Optional feature: define MEM_DMA_CHECKSUM_EN to add the csum output (sum of copied words).
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int unsigned LEN_W = 7,
    parameter int unsigned STEP  = DMA_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      src,
    input  logic [15:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             mem_we,
    output logic [15:0]      mem_a,
    output logic [15:0]      mem_wd,
    input  logic [15:0]      mem_rd
`ifdef MEM_DMA_CHECKSUM_EN
    ,
    output logic [15:0]      csum
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [15:0]      data_q;
    logic [15:0]      sptr;
    logic [15:0]      dptr;
    logic             accept;
    logic             in_write;

    assign accept   = (state_q == IDLE) && start;
    assign in_write = (state_q == WRITE);

    dma_addr_ctr #(.STEP(STEP)) u_src_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .inc      (in_write),
        .load_val (src),
        .ptr      (sptr)
    );

    dma_addr_ctr #(.STEP(STEP)) u_dst_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .inc      (in_write),
        .load_val (dst),
        .ptr      (dptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Words still to copy; the terminating WRITE is the one that sees rem_q == 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
        end else if (accept) begin
            rem_q <= len;
        end else if (in_write) begin
            rem_q <= rem_q - 1'b1;
        end
    end

    // Read data is only consumed in the WRITE that follows, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == READ) begin
            data_q <= mem_rd;
        end
    end

`ifdef MEM_DMA_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            csum <= '0;
        end else if (in_write) begin
            csum <= csum + data_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                mem_a   = sptr;
                state_d = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                mem_we  = 1'b1;
                mem_a   = dptr;
                mem_wd  = data_q;
                state_d = (rem_q == LEN_W'(1)) ? DONE : READ;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed + randomized bench for mem_dma with a 64-word memory and an array-level copy model.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src;
    logic [15:0] dst;
    logic [6:0]  len;
    logic        busy;
    logic        done;
    logic        mem_we;
    logic [15:0] mem_a;
    logic [15:0] mem_wd;
    logic [15:0] mem_rd;
`ifdef MEM_DMA_CHECKSUM_EN
    logic [15:0] csum;
`endif

    always #5 clk = ~clk;

    mem_dma dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .src    (src),
        .dst    (dst),
        .len    (len),
        .busy   (busy),
        .done   (done),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
`ifdef MEM_DMA_CHECKSUM_EN
        ,
        .csum   (csum)
`endif
    );

    // Word memory: combinational read, write on clock edge, bulk preload from img.
    logic [15:0] ram [64];
    logic [15:0] img [64];
    logic [15:0] mdl [64];
    logic        pl_load = 1'b0;

    always @(posedge clk) begin
        if (pl_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= img[i];
        end else if (mem_we) begin
            ram[mem_a[6:1]] <= mem_wd;
        end
    end

    assign mem_rd = ram[mem_a[6:1]];

    int          wr_cnt;
    int          done_cnt;
    logic        odd_seen;
    logic [15:0] rdq [$];

    always @(posedge clk) begin
        if (mem_we) wr_cnt++;
        if (done) done_cnt++;
        if (mem_a[0]) odd_seen = 1'b1;
        if (busy && !mem_we && !done) rdq.push_back(mem_a);
    end

    int tests = 0;
    int fails = 0;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic random_image();
        for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
    endtask

    task automatic load_image();
        for (int i = 0; i < 64; i++) mdl[i] = img[i];
        @(negedge clk);
        pl_load = 1'b1;
        @(negedge clk);
        pl_load = 1'b0;
    endtask

    // Reference: ascending word-by-word copy on the 64-word aliased memory.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                              output logic [15:0] sum);
        logic [5:0] ws;
        logic [5:0] wd;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            ws = 6'((int'(s[15:1]) + i) & 63);
            wd = 6'((int'(d[15:1]) + i) & 63);
            mdl[wd] = mdl[ws];
            sum = sum + mdl[wd];
        end
    endtask

    task automatic compare_ram(input string tag);
        for (int i = 0; i < 64; i++)
            check16($sformatf("%s ram[%0d]", tag, i), ram[i], mdl[i]);
    endtask

    task automatic do_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                           input int repulse_k, output int done_k, output int busy_k);
        @(negedge clk);
        wr_cnt   = 0;
        done_cnt = 0;
        odd_seen = 1'b0;
        rdq.delete();
        src   = s;
        dst   = d;
        len   = 7'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src   = 16'h1234;
        dst   = 16'h5678;
        len   = 7'd9;
        done_k = -1;
        busy_k = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start = (k == repulse_k);
            if (busy) busy_k++;
            if (done && done_k < 0) done_k = k;
            if (!busy && done_k > 0) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int          dk;
        int          bk;
        int          n;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] sum;

        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        wr_cnt = 0;
        done_cnt = 0;
        odd_seen = 1'b0;
        repeat (3) @(negedge clk);
        check16("rst busy", 16'(busy), 16'h0);
        check16("rst done", 16'(done), 16'h0);
        check16("rst mem_we", 16'(mem_we), 16'h0);
        check16("rst mem_a", mem_a, 16'h0000);
        check16("rst mem_wd", mem_wd, 16'h0000);
`ifdef MEM_DMA_CHECKSUM_EN
        check16("rst csum", csum, 16'h0000);
`endif
        reset = 1'b0;

        // Basic 4-word copy to 0x0040.
        random_image();
        img[0] = 16'h0A3C; img[1] = 16'h0A4D; img[2] = 16'h2B7C; img[3] = 16'h24D4;
        load_image();
        model_copy(16'h0000, 16'h0040, 4, sum);
        do_xfer(16'h0000, 16'h0040, 4, 0, dk, bk);
        checki("t1 done cycle", dk, 9);
        checki("t1 writes", wr_cnt, 4);
        checki("t1 done pulses", done_cnt, 1);
        checki("t1 busy cycles", bk, 9);
        check16("t1 ram32", ram[32], 16'h0A3C);
        check16("t1 ram33", ram[33], 16'h0A4D);
        check16("t1 ram34", ram[34], 16'h2B7C);
        check16("t1 ram35", ram[35], 16'h24D4);
        compare_ram("t1");
`ifdef MEM_DMA_CHECKSUM_EN
        check16("t1 csum", csum, sum);
`endif

        // Zero-length transfer.
        do_xfer(16'h0010, 16'h0020, 0, 0, dk, bk);
        checki("t2 done cycle", dk, 1);
        checki("t2 writes", wr_cnt, 0);
        checki("t2 busy cycles", bk, 1);
        checki("t2 reads", rdq.size(), 0);

        // Odd byte addresses are forced even.
        random_image();
        load_image();
        model_copy(16'h0001, 16'h0021, 2, sum);
        do_xfer(16'h0001, 16'h0021, 2, 0, dk, bk);
        check16("t3 odd addr seen", 16'(odd_seen), 16'h0);
        check16("t3 ram16", ram[16], img[0]);
        check16("t3 ram17", ram[17], img[1]);
        checki("t3 done cycle", dk, 5);

        // start re-pulsed mid-transfer is ignored.
        random_image();
        load_image();
        model_copy(16'h0008, 16'h0070, 3, sum);
        do_xfer(16'h0008, 16'h0070, 3, 3, dk, bk);
        checki("t4 writes", wr_cnt, 3);
        checki("t4 done pulses", done_cnt, 1);
        checki("t4 done cycle", dk, 7);
        repeat (4) @(negedge clk);
        check16("t4 idle after", 16'(busy), 16'h0);
        checki("t4 writes after", wr_cnt, 3);
        compare_ram("t4");

        // Reset before the second word's WRITE: only dst word 0 lands.
        random_image();
        load_image();
        @(negedge clk);
        wr_cnt = 0;
        src = 16'h0000; dst = 16'h0040; len = 7'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check16("t5 busy", 16'(busy), 16'h0);
        check16("t5 mem_we", 16'(mem_we), 16'h0);
        check16("t5 done", 16'(done), 16'h0);
        check16("t5 mem_a", mem_a, 16'h0000);
        reset = 1'b0;
        check16("t5 ram32", ram[32], img[0]);
        check16("t5 ram33", ram[33], img[33]);
        checki("t5 writes", wr_cnt, 1);

        // Source address wraps 0xFFFE -> 0x0000.
        random_image();
        load_image();
        model_copy(16'hFFFE, 16'h0090, 2, sum);
        do_xfer(16'hFFFE, 16'h0090, 2, 0, dk, bk);
        checki("t6 reads", rdq.size(), 2);
        if (rdq.size() >= 2) begin
            check16("t6 rd addr0", rdq[0], 16'hFFFE);
            check16("t6 rd addr1", rdq[1], 16'h0000);
        end
        compare_ram("t6");

        // Randomized transfers, including overlapping ranges.
        for (int t = 0; t < 6; t++) begin
            random_image();
            load_image();
            s = 16'($urandom_range(0, 127));
            d = (t == 0) ? s + 16'd2 : 16'($urandom_range(0, 127));
            n = $urandom_range(1, 20);
            model_copy(s, d, n, sum);
            do_xfer(s, d, n, 0, dk, bk);
            checki($sformatf("r%0d done cycle", t), dk, 1 + 2 * n);
            checki($sformatf("r%0d writes", t), wr_cnt, n);
            compare_ram($sformatf("r%0d", t));
`ifdef MEM_DMA_CHECKSUM_EN
            check16($sformatf("r%0d csum", t), csum, sum);
`endif
        end

`ifdef MEM_DMA_CHECKSUM_EN
        // Checksum wraps modulo 2**16 and holds after completion.
        random_image();
        img[0] = 16'h0001; img[1] = 16'hFFFF; img[2] = 16'h0010;
        load_image();
        do_xfer(16'h0000, 16'h0060, 3, 0, dk, bk);
        check16("cs wrap", csum, 16'h0010);
        repeat (3) @(negedge clk);
        check16("cs hold", csum, 16'h0010);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
